inst_encoder: RTL and testbench

- Field-to-word instruction encoder; inverse of the instruction decoder.
- Accepts decoded RV32I fields plus a 32-bit immediate over a valid/ready handshake.
- Packs them into a 32-bit instruction word according to the format implied by the opcode, and emits the word with a byte address for instruction-memory loading.
- Sits between the test/boot loader and the IM write port; one register stage, full throughput.

---
 rtl/inst_encoder_pkg.sv | 57 +++++
 rtl/inst_encoder_if.sv | 65 ++++++
 rtl/inst_encoder_pack.sv | 79 +++++++
 rtl/inst_encoder.sv | 136 +++++++++++++
 tb/tb_inst_encoder.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_encoder_pkg.sv
// -----------------------------------------------------------------------------
// inst_encoder_pkg
// Definitions shared by the RV32I instruction encoder (and its decoder twin).
// The opcode constants are the 5-bit inst[6:2] values. inst[1:0] is always
// 2'b11 for RV32I, so it is not part of these constants.
//   OPC_*      : major opcode values
//   fmt_e      : instruction format selected by the opcode
//   NOP_INST   : canonical NOP (addi x0,x0,0), emitted for unsupported opcodes
//   opc_to_fmt : opcode -> format lookup
// -----------------------------------------------------------------------------
package inst_encoder_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Low two bits shared by every 32-bit RV32I instruction.
    localparam logic [1:0] INST_LEN_BITS = 2'b11;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } fmt_e;

    // Maps the major opcode to its encoding format. Shift-immediate
    // instructions are still FMT_I here; the packer handles their
    // func7-in-the-immediate special case.
    function automatic fmt_e opc_to_fmt(input logic [4:0] opc);
        fmt_e fmt;
        case (opc)
            OPC_OP:                          fmt = FMT_R;
            OPC_OPIMM, OPC_LOAD,
            OPC_JALR, OPC_SYSTEM:            fmt = FMT_I;
            OPC_STORE:                       fmt = FMT_S;
            OPC_BRANCH:                      fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:              fmt = FMT_U;
            OPC_JAL:                         fmt = FMT_J;
            default:                         fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// -----------------------------------------------------------------------------
// inst_encoder_if
// Bundles the two handshakes of the instruction encoder.
//   Input side  : in_valid/in_ready plus the decoded field tuple
//                 (opcode, func3, func7, rs1/rs2/rd indices, 32-bit immediate).
//   Output side : out_valid/out_ready plus the encoded word, its byte address
//                 and the illegal-opcode flag.
// Modports:
//   master : the loader/sink side. It drives the fields and out_ready.
//   slave  : the encoder itself.
// -----------------------------------------------------------------------------
interface inst_encoder_if #(
    parameter int ADDR_WIDTH = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4:0]            in_opcode;
    logic [2:0]            in_func3;
    logic [6:0]            in_func7;
    logic [4:0]            in_rs1_index;
    logic [4:0]            in_rs2_index;
    logic [4:0]            in_rd_index;
    logic [31:0]           in_imm;

    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_inst;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_illegal;

    modport master (
        output in_valid,
        input  in_ready,
        output in_opcode,
        output in_func3,
        output in_func7,
        output in_rs1_index,
        output in_rs2_index,
        output in_rd_index,
        output in_imm,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_addr,
        input  out_illegal
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_opcode,
        input  in_func3,
        input  in_func7,
        input  in_rs1_index,
        input  in_rs2_index,
        input  in_rd_index,
        input  in_imm,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_addr,
        output out_illegal
    );

endinterface

// File: rtl/inst_encoder_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
// Purely combinational RV32I field packer. It selects the format from the
// opcode and places the fields and immediate slices into a 32-bit word.
// Unsupported opcodes yield NOP_INST with illegal_o set.
// Ports:
//   opcode_i   inst[6:2]
//   func3_i    inst[14:12]
//   func7_i    inst[31:25] (R-type, and the upper bits of shift-immediates)
//   rs1_i, rs2_i, rd_i   register indices
//   imm_i      sign-extended immediate / byte offset
//   inst_o     packed instruction word
//   illegal_o  opcode not supported
// -----------------------------------------------------------------------------
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [4:0]  opcode_i,
    input  logic [2:0]  func3_i,
    input  logic [6:0]  func7_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] imm_i,
    output logic [31:0] inst_o,
    output logic        illegal_o
);

    fmt_e fmt;
    logic is_shift_imm;

    assign fmt = opc_to_fmt(opcode_i);

    // SLLI/SRLI/SRAI carry func7 (e.g. the SRAI 0100000 marker) in the
    // upper immediate bits. The shift amount is imm[4:0].
    assign is_shift_imm = (opcode_i == OPC_OPIMM) &&
                          ((func3_i == 3'b001) || (func3_i == 3'b101));

    always_comb begin
        inst_o    = NOP_INST;
        illegal_o = 1'b0;
        unique case (fmt)
            FMT_R: begin
                inst_o = {func7_i, rs2_i, rs1_i, func3_i, rd_i,
                          opcode_i, INST_LEN_BITS};
            end
            FMT_I: begin
                if (is_shift_imm) begin
                    inst_o = {func7_i, imm_i[4:0], rs1_i, func3_i, rd_i,
                              opcode_i, INST_LEN_BITS};
                end else begin
                    inst_o = {imm_i[11:0], rs1_i, func3_i, rd_i,
                              opcode_i, INST_LEN_BITS};
                end
            end
            FMT_S: begin
                inst_o = {imm_i[11:5], rs2_i, rs1_i, func3_i, imm_i[4:0],
                          opcode_i, INST_LEN_BITS};
            end
            FMT_B: begin
                // Branch offsets are 2-byte aligned, so imm[0] is not encoded.
                inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, func3_i,
                          imm_i[4:1], imm_i[11], opcode_i, INST_LEN_BITS};
            end
            FMT_U: begin
                inst_o = {imm_i[31:12], rd_i, opcode_i, INST_LEN_BITS};
            end
            FMT_J: begin
                inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                          rd_i, opcode_i, INST_LEN_BITS};
            end
            default: begin
                inst_o    = NOP_INST;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Field-to-word RV32I encoder that sits in front of the instruction-memory
// write port. It has one output register stage with full throughput: a new
// tuple can be accepted in the same cycle the held word is taken.
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   clear        synchronous restart: drops the held word and reloads the
//                address counter. illegal_cnt is kept.
//   bus          inst_encoder_if.slave: the input field handshake and the
//                output word/address handshake
//   illegal_cnt  saturating count of emitted illegal (NOP-substituted) words
// Parameters:
//   ADDR_WIDTH   byte-address width of out_addr (wraps modulo 2^ADDR_WIDTH)
//   BASE_ADDR    address of the first word after reset or clear
// -----------------------------------------------------------------------------
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 14,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    inst_encoder_if.slave       bus,
    output logic [7:0]          illegal_cnt
);

    // Output register occupancy.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(4);

    logic [0:0]            state_q, state_d;
    logic [31:0]           inst_q,  inst_d;
    logic                  ill_q,   ill_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [7:0]            cnt_q,   cnt_d;

    logic [31:0]           pack_inst;
    logic                  pack_illegal;
    logic                  in_ready;
    logic                  in_accept;
    logic                  out_hs;

    inst_pack u_pack (
        .opcode_i  (bus.in_opcode),
        .func3_i   (bus.in_func3),
        .func7_i   (bus.in_func7),
        .rs1_i     (bus.in_rs1_index),
        .rs2_i     (bus.in_rs2_index),
        .rd_i      (bus.in_rd_index),
        .imm_i     (bus.in_imm),
        .inst_o    (pack_inst),
        .illegal_o (pack_illegal)
    );

    // A slot is free when the register is empty, or when its word is leaving
    // this cycle. That makes in_ready a combinational pass-through of out_ready.
    assign in_ready  = (state_q == ST_EMPTY) || bus.out_ready;
    assign in_accept = bus.in_valid && in_ready;
    assign out_hs    = (state_q == ST_FULL) && bus.out_ready;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        ill_d   = ill_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;

        // out_addr always names the held word. The counter therefore moves
        // past a word when that word leaves, so any word loaded on the same
        // edge gets the next address.
        if (out_hs) begin
            addr_d = addr_q + ADDR_STEP;
            if (ill_q && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        case (state_q)
            ST_EMPTY: begin
                if (in_accept) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_hs && !in_accept) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (in_accept) begin
            inst_d = pack_inst;
            ill_d  = pack_illegal;
        end

        // clear wins over a same-cycle accept. A word the sink takes on this
        // edge has still been emitted, so the illegal count is left as computed.
        if (clear) begin
            state_d = ST_EMPTY;
            inst_d  = '0;
            ill_d   = 1'b0;
            addr_d  = BASE_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            inst_q  <= '0;
            ill_q   <= 1'b0;
            addr_q  <= BASE_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            ill_q   <= ill_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state_q == ST_FULL);
    assign bus.out_inst    = inst_q;
    assign bus.out_addr    = addr_q;
    assign bus.out_illegal = ill_q;
    assign illegal_cnt     = cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// -----------------------------------------------------------------------------
// tb_inst_encoder
// Two encoder instances share one stimulus stream: a 14-bit-address one and a
// 4-bit-address one, which shows address wrap-around quickly. A behavioural
// model tracks the held word, the running byte address and the illegal count.
// A negedge compare process checks both DUTs every cycle. Directed sections
// add literal expectations from hand-assembled RV32I words.
// -----------------------------------------------------------------------------
module tb_inst_encoder;

    logic clk;
    logic rst;
    logic clear;
    logic [7:0] cnt1, cnt4;

    inst_encoder_if #(.ADDR_WIDTH(14)) bus  ();
    inst_encoder_if #(.ADDR_WIDTH(4))  bus4 ();

    inst_encoder #(.ADDR_WIDTH(14), .BASE_ADDR(14'h0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus), .illegal_cnt(cnt1)
    );

    inst_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(4'h0)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus4), .illegal_cnt(cnt4)
    );

    assign bus4.in_valid     = bus.in_valid;
    assign bus4.in_opcode    = bus.in_opcode;
    assign bus4.in_func3     = bus.in_func3;
    assign bus4.in_func7     = bus.in_func7;
    assign bus4.in_rs1_index = bus.in_rs1_index;
    assign bus4.in_rs2_index = bus.in_rs2_index;
    assign bus4.in_rd_index  = bus.in_rd_index;
    assign bus4.in_imm       = bus.in_imm;
    assign bus4.out_ready    = bus.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder written from the format tables as shifted and masked
    // field sums.
    function automatic logic [31:0] ref_encode(
        input int unsigned opc, input int unsigned f3, input int unsigned f7,
        input int unsigned rs1, input int unsigned rs2, input int unsigned rd,
        input int unsigned imm, output bit ill);
        int unsigned w;
        ill = 1'b0;
        w   = opc * 4 + 3;
        case (opc)
            12: w += (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7);
            0, 25, 28:
                w += ((imm & 32'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7);
            4: begin
                if (f3 == 1 || f3 == 5)
                    w += (f7 << 25) + ((imm & 31) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7);
                else
                    w += ((imm & 32'hFFF) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7);
            end
            8:  w += (((imm >> 5) & 127) << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12)
                   + ((imm & 31) << 7);
            24: w += (((imm >> 12) & 1) << 31) + (((imm >> 5) & 63) << 25) + (rs2 << 20)
                   + (rs1 << 15) + (f3 << 12) + (((imm >> 1) & 15) << 8) + (((imm >> 11) & 1) << 7);
            13, 5: w += (imm & 32'hFFFF_F000) + (rd << 7);
            27: w += (((imm >> 20) & 1) << 31) + (((imm >> 1) & 1023) << 21)
                   + (((imm >> 11) & 1) << 20) + (((imm >> 12) & 255) << 12) + (rd << 7);
            default: begin
                w   = 32'h0000_0013;
                ill = 1'b1;
            end
        endcase
        return w;
    endfunction

    // Behavioural model of the one-deep output stage.
    bit          m_valid;
    logic [31:0] m_inst;
    bit          m_ill;
    int unsigned m_addr;
    int unsigned m_cnt;

    always @(posedge clk) begin
        automatic bit hs, acc, il;
        automatic logic [31:0] w;
        if (rst) begin
            m_valid <= 1'b0; m_inst <= '0; m_ill <= 1'b0; m_addr <= 0; m_cnt <= 0;
        end else begin
            hs  = m_valid && bus.out_ready;
            acc = bus.in_valid && (!m_valid || bus.out_ready);
            if (hs && m_ill && m_cnt < 255) m_cnt <= m_cnt + 1;
            if (clear) begin
                m_valid <= 1'b0; m_inst <= '0; m_ill <= 1'b0; m_addr <= 0;
            end else begin
                if (hs) m_addr <= m_addr + 4;
                if (acc) begin
                    w = ref_encode(bus.in_opcode, bus.in_func3, bus.in_func7, bus.in_rs1_index,
                                   bus.in_rs2_index, bus.in_rd_index, bus.in_imm, il);
                    m_inst  <= w;
                    m_ill   <= il;
                    m_valid <= 1'b1;
                end else if (hs) begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",     32'(bus.in_ready),     32'(!m_valid || bus.out_ready));
            check("out_valid",    32'(bus.out_valid),    32'(m_valid));
            check("out_inst",     bus.out_inst,          m_inst);
            check("out_illegal",  32'(bus.out_illegal),  32'(m_ill));
            check("out_addr",     32'(bus.out_addr),     m_addr & 32'h3FFF);
            check("illegal_cnt",  32'(cnt1),             m_cnt);
            check("w4_out_valid", 32'(bus4.out_valid),   32'(m_valid));
            check("w4_out_inst",  bus4.out_inst,         m_inst);
            check("w4_out_addr",  32'(bus4.out_addr),    m_addr & 32'hF);
            check("w4_cnt",       32'(cnt4),             m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned opc, input int unsigned f3, input int unsigned f7,
                         input int unsigned rs1, input int unsigned rs2, input int unsigned rd,
                         input int unsigned imm);
        bus.in_valid     = 1'b1;
        bus.in_opcode    = 5'(opc);
        bus.in_func3     = 3'(f3);
        bus.in_func7     = 7'(f7);
        bus.in_rs1_index = 5'(rs1);
        bus.in_rs2_index = 5'(rs2);
        bus.in_rd_index  = 5'(rd);
        bus.in_imm       = imm;
    endtask

    // Format sweep: addi x1,x0,-1 / sw x2,8(x1) / beq x1,x2,+8 / lui x5,0x12345 / jal x1,+16
    int unsigned sw_opc[5] = '{4, 8, 24, 13, 27};
    int unsigned sw_f3 [5] = '{0, 2, 0, 0, 0};
    int unsigned sw_rs1[5] = '{0, 1, 1, 0, 0};
    int unsigned sw_rs2[5] = '{0, 2, 2, 0, 0};
    int unsigned sw_rd [5] = '{1, 0, 0, 5, 1};
    int unsigned sw_imm[5] = '{32'hFFFF_FFFF, 8, 8, 32'h1234_5000, 16};
    logic [31:0] sw_exp[5] = '{32'hFFF0_0093, 32'h0020_A423, 32'h0020_8463,
                               32'h1234_52B7, 32'h0100_00EF};
    int unsigned legal_opc[10] = '{0, 4, 5, 8, 12, 13, 24, 25, 27, 28};

    initial begin
        bit il;
        rst = 1'b1;
        clear = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        check("rst_out_valid",   32'(bus.out_valid),   32'd0);
        check("rst_out_inst",    bus.out_inst,         32'd0);
        check("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
        check("rst_out_addr",    32'(bus.out_addr),    32'd0);
        check("rst_illegal_cnt", 32'(cnt1),            32'd0);
        check("rst_in_ready",    32'(bus.in_ready),    32'd1);
        chk_en = 1'b1;

        // Pin the model against hand-assembled words.
        check("model_add", ref_encode(12, 0, 0, 1, 2, 3, 0, il), 32'h0020_81B3);
        check("model_srai", ref_encode(4, 5, 32, 1, 0, 2, 3, il), 32'h4030_D113);
        check("model_ill", ref_encode(31, 0, 0, 0, 0, 0, 0, il), 32'h0000_0013);

        // add x3,x1,x2
        drive(12, 0, 0, 1, 2, 3, 0);
        tick();
        bus.in_valid = 1'b0;
        check("add_inst",  bus.out_inst,         32'h0020_81B3);
        check("add_addr",  32'(bus.out_addr),    32'h0);
        check("add_valid", 32'(bus.out_valid),   32'd1);
        $display("add   addr=0x%04h inst=0x%08h", bus.out_addr, bus.out_inst);
        tick();

        // Format sweep after a clear, back to back, with no bubbles.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(sw_opc[i], sw_f3[i], 0, sw_rs1[i], sw_rs2[i], sw_rd[i], sw_imm[i]);
            tick();
            check("sweep_inst",  bus.out_inst,        sw_exp[i]);
            check("sweep_addr",  32'(bus.out_addr),   32'(4 * i));
            check("sweep_valid", 32'(bus.out_valid),  32'd1);
            check("wrap_addr",   32'(bus4.out_addr),  32'((4 * i) % 16));
            $display("sweep addr=0x%04h wrap_addr=0x%0h inst=0x%08h",
                     bus.out_addr, bus4.out_addr, bus.out_inst);
        end
        bus.in_valid = 1'b0;
        tick();

        // Backpressure: A is held for 3 cycles while B waits at the input.
        bus.out_ready = 1'b0;
        drive(12, 0, 0, 1, 2, 4, 0);             // add x4,x1,x2
        tick();
        drive(12, 0, 32, 1, 2, 5, 0);            // sub x5,x1,x2
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_hold_inst", bus.out_inst,       32'h0020_8233);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("bp_next_inst", bus.out_inst, 32'h4020_82B3);
        $display("bp    addr=0x%04h inst=0x%08h", bus.out_addr, bus.out_inst);
        tick();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Reset while FULL.
        drive(12, 0, 0, 1, 2, 4, 0);
        tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_valid", 32'(bus.out_valid), 32'd0);
        check("rstmid_addr",  32'(bus.out_addr),  32'd0);

        // Illegal opcode.
        drive(31, 0, 0, 1, 2, 3, 32'h1234);
        tick();
        bus.in_valid = 1'b0;
        check("ill_inst",    bus.out_inst,          32'h0000_0013);
        check("ill_flag",    32'(bus.out_illegal),  32'd1);
        check("ill_cnt_pre", 32'(cnt1),             32'd0);
        $display("ill   addr=0x%04h inst=0x%08h", bus.out_addr, bus.out_inst);
        tick();
        check("ill_cnt_post", 32'(cnt1), 32'd1);

        // clear coincident with in_valid: that input is discarded and the count is kept.
        drive(12, 0, 0, 1, 2, 4, 0);
        tick();
        drive(31, 0, 0, 0, 0, 0, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_valid", 32'(bus.out_valid), 32'd0);
        check("clr_addr",  32'(bus.out_addr),  32'd0);
        check("clr_cnt",   32'(cnt1),          32'd1);
        tick();
        check("clr_no_emit", 32'(bus.out_valid), 32'd0);
        check("clr_cnt2",    32'(cnt1),          32'd1);

        // Randomized traffic. The model is checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            int unsigned opc;
            opc = ($urandom_range(9) < 4) ? legal_opc[$urandom_range(9)] : $urandom_range(31);
            drive(opc, $urandom_range(7), $urandom_range(127), $urandom_range(31),
                  $urandom_range(31), $urandom_range(31), $urandom);
            bus.in_valid  = ($urandom_range(9) < 7);
            bus.out_ready = ($urandom_range(9) < 7);
            clear         = ($urandom_range(99) == 0);
            tick();
        end
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick(); tick();
        check("cnt_saturated", 32'(cnt1), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
